// File: rtl/ram_pkg.sv
// Shared definitions for the single-port synchronous-read RAM and its masters:
// default geometry, depth derivation and the read-master state encoding.
package ram_pkg;

    localparam int AWIDTH_DEFAULT = 3;
    localparam int DWIDTH_DEFAULT = 32;

    // Number of words addressable with an address of the given width.
    function automatic int depth_of(input int awidth);
        return 1 << awidth;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO of {last, data} words returned by the RAM. The head entry
// drives the stream outputs directly from flops, and the valid flag is
// registered as well. Pushes are guaranteed by the issuer never to overflow.
module ram_rd_skid #(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              push_last,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DWIDTH-1:0] head_data,
    output logic              head_last,
    output logic              head_valid
);

    typedef struct packed {
        logic              last;
        logic [DWIDTH-1:0] data;
    } entry_t;

    entry_t     head_q;
    entry_t     tail_q;
    entry_t     push_entry;
    logic [1:0] count_q;
    logic [1:0] count_next;

    assign push_entry = '{last: push_last, data: push_data};

    // Occupancy after this cycle's push/pop.
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + 2'd1;
        end else if (pop && !push) begin
            count_next = count_q - 2'd1;
        end
    end

    // Move entries toward the head; the tail only fills when the head is occupied.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the two entries are reset (unlike a real memory) because the head
            // directly drives m_data/m_last, which must read zero out of reset.
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            head_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            unique case (count_q)
                2'd0: begin
                    if (push) head_q <= push_entry;
                end
                2'd1: begin
                    if (push && pop)  head_q <= push_entry;
                    else if (push)    tail_q <= push_entry;
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) tail_q <= push_entry;
                    end
                end
            endcase
            count_q    <= count_next;
            head_valid <= (count_next != 2'd0);
        end
    end

    assign count     = count_q;
    assign head_data = head_q.data;
    assign head_last = head_q.last;

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read master for the synchronous-read RAM. A start command latches
// base/count, then sequential reads are issued under a two-word credit so the
// skid FIFO never overflows; returned words leave as a valid/ready stream.
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEFAULT,
    parameter int DWIDTH = DWIDTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   count,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_we,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(depth_of(AWIDTH) - 1);
    localparam logic [AWIDTH-1:0] ADDR_ONE  = AWIDTH'(1);
    localparam logic [AWIDTH:0]   CNT_ONE   = (AWIDTH+1)'(1);

    rd_state_t       state;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH:0] issued;
    logic [AWIDTH:0] burst_len;
    logic            inflight;
    logic            inflight_last;
    logic [1:0]      fifo_count;
    logic [1:0]      occupancy;
    logic            pop;
    logic            rd_fire;
    logic            is_last_issue;

    // A popped slot frees credit in the same cycle, which keeps the stream gap-free.
    assign pop           = m_valid & m_ready;
    assign occupancy     = fifo_count + {1'b0, inflight};
    assign rd_fire       = (state == ST_RUN) && (issued < burst_len) &&
                           ((occupancy < 2'd2) || pop);
    assign is_last_issue = ((issued + CNT_ONE) == burst_len);

    assign ram_addr = addr;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;

    // Burst FSM with the address/issue counters and the one-deep in-flight tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr          <= '0;
            issued        <= '0;
            burst_len     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= rd_fire;
            inflight_last <= rd_fire && is_last_issue;
            if (rd_fire) begin
                addr   <= (addr == LAST_ADDR) ? '0 : addr + ADDR_ONE;
                issued <= issued + CNT_ONE;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        burst_len <= count;
                        issued    <= '0;
                        if (count != '0) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (pop && m_last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ram_rd_skid #(.DWIDTH(DWIDTH)) u_skid (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight),
        .push_last  (inflight_last),
        .push_data  (ram_dout),
        .pop        (pop),
        .count      (fifo_count),
        .head_data  (m_data),
        .head_last  (m_last),
        .head_valid (m_valid)
    );

endmodule
